// File: rtl/lcd_status_display.sv
// HD44780 16x2 character LCD driver: one-time power-up/init sequence, then continuous
// refresh of both lines from a host-writable 32-byte text buffer. Write-only, fixed-cycle pacing.
module lcd_status_display #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int EN_CYCLES      = 25,
    parameter int CMD_CYCLES     = 2500,
    parameter int CLEAR_CYCLES   = 100000
) (
    input  logic       clk50mhz,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       frame_pulse,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON
);

    localparam int MAX_A   = (POWERUP_CYCLES > EN_CYCLES) ? POWERUP_CYCLES : EN_CYCLES;
    localparam int MAX_B   = (CMD_CYCLES > CLEAR_CYCLES) ? CMD_CYCLES : CLEAR_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PWRUP,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next, hold_last;
    logic [5:0]    step, step_next;
    logic          init_next, frame_next, load;
    logic [7:0]    next_byte;
    logic          next_rs;
    logic [4:0]    char_idx;
    logic [7:0]    text_buf [32];

    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                text_buf[i] <= 8'h20;
            end
        end else if (wr_en) begin
            text_buf[wr_addr] <= wr_data;
        end
    end

    // Only the clear command needs the long settle time.
    assign hold_last = (!LCD_RS && LCD_DATA == 8'h01) ? CLR_LAST : CMD_LAST;

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        step_next  = step;
        init_next  = init_done;
        frame_next = 1'b0;
        load       = 1'b0;
        case (state)
            S_PWRUP: begin
                if (cnt == PWR_LAST) begin
                    state_next = S_SETUP;
                    cnt_next   = '0;
                    load       = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_next = S_PULSE;
                    cnt_next   = '0;
                end
            end
            S_PULSE: begin
                if (cnt == EN_LAST) begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                end
            end
            S_HOLD: begin
                if (cnt == hold_last) begin
                    state_next = S_SETUP;
                    cnt_next   = '0;
                    load       = 1'b1;
                    if (!init_done) begin
                        if (step == 6'd5) begin
                            step_next = '0;
                            init_next = 1'b1;
                        end else begin
                            step_next = step + 6'd1;
                        end
                    end else if (step == 6'd33) begin
                        step_next  = '0;
                        frame_next = 1'b1;
                    end else begin
                        step_next = step + 6'd1;
                    end
                end
            end
            default: begin
                state_next = S_PWRUP;
                cnt_next   = '0;
            end
        endcase
    end

    // Byte for the transfer about to start; the buffer read here sees pre-edge contents.
    always_comb begin
        next_byte = 8'h00;
        next_rs   = 1'b0;
        char_idx  = '0;
        if (!init_next) begin
            case (step_next)
                6'd0, 6'd1, 6'd2: next_byte = 8'h38;
                6'd3:             next_byte = 8'h0C;
                6'd4:             next_byte = 8'h01;
                default:          next_byte = 8'h06;
            endcase
        end else if (step_next == 6'd0) begin
            next_byte = 8'h80;
        end else if (step_next == 6'd17) begin
            next_byte = 8'hC0;
        end else begin
            next_rs   = 1'b1;
            char_idx  = (step_next < 6'd17) ? 5'(step_next - 6'd1) : 5'(step_next - 6'd2);
            next_byte = text_buf[char_idx];
        end
    end

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            state       <= S_PWRUP;
            cnt         <= '0;
            step        <= '0;
            init_done   <= 1'b0;
            frame_pulse <= 1'b0;
            LCD_EN      <= 1'b0;
            LCD_RS      <= 1'b0;
            LCD_DATA    <= 8'h00;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            step        <= step_next;
            init_done   <= init_next;
            frame_pulse <= frame_next;
            LCD_EN      <= (state_next == S_PULSE);
            if (load) begin
                LCD_DATA <= next_byte;
                LCD_RS   <= next_rs;
            end
        end
    end

endmodule

// File: tb/tb_lcd_status_display.sv
// Scoreboard bench for lcd_status_display: expected transfers are queued as stimulus is
// driven and matched against each LCD_EN falling edge.
module tb_lcd_status_display;

    localparam int P_PWR    = 10;
    localparam int P_EN     = 2;
    localparam int P_CMD    = 4;
    localparam int P_CLR    = 8;
    localparam int XFER     = 2 + P_EN + P_CMD;
    localparam int INIT_END = P_PWR + 5 * XFER + (2 + P_EN + P_CLR);
    localparam int PASS     = 34 * XFER;

    logic       clk50mhz = 1'b0;
    logic       reset    = 1'b1;
    logic       wr_en    = 1'b0;
    logic [4:0] wr_addr  = '0;
    logic [7:0] wr_data  = '0;
    logic       init_done, frame_pulse;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;

    lcd_status_display #(
        .POWERUP_CYCLES(P_PWR),
        .EN_CYCLES     (P_EN),
        .CMD_CYCLES    (P_CMD),
        .CLEAR_CYCLES  (P_CLR)
    ) dut (
        .clk50mhz   (clk50mhz),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .init_done  (init_done),
        .frame_pulse(frame_pulse),
        .LCD_DATA   (LCD_DATA),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_EN     (LCD_EN),
        .LCD_ON     (LCD_ON),
        .LCD_BLON   (LCD_BLON)
    );

    always #5 clk50mhz = ~clk50mhz;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb[$];
    logic [7:0] model[32];

    int         cyc = 0;
    bit         mon_en = 1'b0;
    int         frames = 0;
    int         xfers = 0;
    int         rise_cyc = -1;
    int         init_cyc = -1;
    logic       prev_en = 1'b0;
    logic       prev_init = 1'b0;
    logic [8:0] prev_word = '0;
    logic [8:0] exp_word;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        checks++;
    endtask

    task automatic applyStimulus(input logic [4:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk50mhz);
        wr_en   = 1'b0;
    endtask

    task automatic pushInit();
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h38});
        sb.push_back({1'b0, 8'h0C});
        sb.push_back({1'b0, 8'h01});
        sb.push_back({1'b0, 8'h06});
    endtask

    task automatic pushPass();
        sb.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) sb.push_back({1'b1, model[i]});
        sb.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) sb.push_back({1'b1, model[i]});
    endtask

    task automatic waitCyc(input int n);
        for (int i = 0; i < 5000 && cyc != n; i++) @(negedge clk50mhz);
        checkOutput($sformatf("reach_cyc_%0d", n), cyc, n);
    endtask

    task automatic waitFrames(input int n);
        for (int i = 0; i < 3000 && frames < n; i++) @(negedge clk50mhz);
        checkOutput($sformatf("frames_%0d", n), frames, n);
    endtask

    always @(posedge clk50mhz) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: protocol invariants, scoreboard pops on EN fall, timing capture.
    always @(negedge clk50mhz) begin
        checkOutput("rw_const", LCD_RW, 1'b0);
        checkOutput("on_const", LCD_ON, 1'b1);
        checkOutput("blon_const", LCD_BLON, 1'b1);
        if (reset) begin
            frames   = 0;
            rise_cyc = -1;
            init_cyc = -1;
        end else if (mon_en) begin
            if (prev_en) checkOutput("stable_while_en", {LCD_RS, LCD_DATA}, prev_word);
            if (!prev_en && LCD_EN && rise_cyc < 0) rise_cyc = cyc;
            if (!prev_init && init_done && init_cyc < 0) init_cyc = cyc;
            if (prev_en && !LCD_EN) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $error("[TB] FAIL sb_underflow: observed %0h expected none", {LCD_RS, LCD_DATA});
                end else begin
                    exp_word = sb.pop_front();
                    checkOutput($sformatf("xfer_%0d", xfers), {LCD_RS, LCD_DATA}, exp_word);
                end
                xfers++;
            end
            if (frame_pulse) begin
                checkOutput($sformatf("frame%0d_cyc", frames), cyc, INIT_END + PASS * (frames + 1));
                frames++;
            end
        end
        prev_en   = LCD_EN;
        prev_init = init_done;
        prev_word = {LCD_RS, LCD_DATA};
    end

    initial begin
        string line1;
        string line2;
        line1 = "VECTOR-06C";
        line2 = "OK";
        for (int i = 0; i < 32; i++) model[i] = 8'h20;

        repeat (3) @(negedge clk50mhz);
        checkOutput("rst_en", LCD_EN, 1'b0);
        checkOutput("rst_rs", LCD_RS, 1'b0);
        checkOutput("rst_data", LCD_DATA, 8'h00);
        checkOutput("rst_init", init_done, 1'b0);
        checkOutput("rst_frame", frame_pulse, 1'b0);

        reset  = 1'b0;
        mon_en = 1'b1;
        pushInit();

        for (int i = 0; i < line1.len(); i++) begin
            applyStimulus(5'(i), line1[i]);
            model[i] = line1[i];
        end
        for (int i = 0; i < line2.len(); i++) begin
            applyStimulus(5'(16 + i), line2[i]);
            model[16 + i] = line2[i];
        end

        // Pass 0 plain; pass 1 sees the addr-20 write but not addr-3; pass 2 sends the old
        // addr-5 byte despite the same-edge write; pass 3 carries both later updates.
        pushPass();
        model[20] = 8'h41;
        pushPass();
        model[3] = 8'h42;
        pushPass();
        model[5] = 8'h5A;
        pushPass();

        waitCyc(INIT_END + PASS + 8 * 19 + 0);
        applyStimulus(5'd20, 8'h41);
        applyStimulus(5'd3, 8'h42);

        waitCyc(INIT_END + 2 * PASS + 8 * 6 - 1);
        applyStimulus(5'd5, 8'h5A);

        waitFrames(4);
        checkOutput("first_en_rise", rise_cyc, P_PWR + 2);
        checkOutput("init_done_rise", init_cyc, INIT_END);
        checkOutput("sb_drained", sb.size(), 0);
        checkOutput("xfer_count", xfers, 6 + 4 * 34);

        for (int i = 0; i < 100 && !LCD_EN; i++) @(negedge clk50mhz);
        checkOutput("en_high_before_reset", LCD_EN, 1'b1);
        mon_en = 1'b0;
        sb.delete();
        reset = 1'b1;
        @(negedge clk50mhz);
        checkOutput("midrst_en", LCD_EN, 1'b0);
        checkOutput("midrst_init", init_done, 1'b0);
        checkOutput("midrst_data", LCD_DATA, 8'h00);
        checkOutput("midrst_rs", LCD_RS, 1'b0);
        checkOutput("midrst_frame", frame_pulse, 1'b0);
        @(negedge clk50mhz);
        reset  = 1'b0;
        xfers  = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        pushInit();
        pushPass();

        waitFrames(1);
        checkOutput("re_first_en_rise", rise_cyc, P_PWR + 2);
        checkOutput("re_init_done_rise", init_cyc, INIT_END);
        checkOutput("re_sb_drained", sb.size(), 0);
        checkOutput("re_xfer_count", xfers, 6 + 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
